// File: rtl/round_robin_arbiter_with_lock.sv
// Round-robin arbiter whose grant is held for multi-cycle transactions.
// A grant ends on the holder's last beat, on request drop, or on a hold-limit timeout.
module round_robin_arbiter_with_lock #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         requests,
  input  logic [N-1:0]         lasts,
  output logic [N-1:0]         grants,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 preempted
);

  localparam int ID_W = $clog2(N);
  localparam int HC_W = $clog2(MAX_HOLD + 1);

  // Returns {valid, index} of the first set request after base, wrapping modulo N.
  function automatic logic [ID_W:0] pick_f(input logic [N-1:0] req, input logic [ID_W-1:0] base);
    logic [ID_W:0] res;
    int            cand;
    res = '0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(base) + k) % N;
      if (!res[ID_W] && req[cand]) begin
        res = {1'b1, ID_W'(cand)};
      end
    end
    return res;
  endfunction

  logic [N-1:0]    grants_r;
  logic [ID_W-1:0] grant_id_r;
  logic            busy_r;
  logic            preempted_r;
  logic [ID_W-1:0] ptr_r;
  logic [HC_W-1:0] hold_cnt_r;

  logic [ID_W-1:0] base_s;
  logic [ID_W:0]   pick_s;
  logic            rel_drop_s;
  logic            rel_last_s;
  logic            rel_to_s;
  logic            release_s;

  // Release decode for the current holder and next-winner selection.
  always_comb begin
    base_s     = busy_r ? grant_id_r : ptr_r;
    pick_s     = pick_f(requests, base_s);
    rel_drop_s = ~requests[grant_id_r];
    rel_last_s = requests[grant_id_r] & lasts[grant_id_r];
    rel_to_s   = (hold_cnt_r == HC_W'(MAX_HOLD));
    release_s  = busy_r & (rel_drop_s | rel_last_s | rel_to_s);
  end

  // Grant, pointer and hold-counter state; a hold only counts up while unreleased, so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      grants_r    <= '0;
      grant_id_r  <= '0;
      busy_r      <= 1'b0;
      preempted_r <= 1'b0;
      ptr_r       <= ID_W'(N - 1);
      hold_cnt_r  <= '0;
    end else if (!busy_r || release_s) begin
      preempted_r <= busy_r & rel_to_s & ~rel_drop_s & ~rel_last_s;
      if (pick_s[ID_W]) begin
        grants_r   <= {{(N-1){1'b0}}, 1'b1} << pick_s[ID_W-1:0];
        grant_id_r <= pick_s[ID_W-1:0];
        busy_r     <= 1'b1;
        ptr_r      <= pick_s[ID_W-1:0];
        hold_cnt_r <= HC_W'(1);
      end else begin
        grants_r   <= '0;
        busy_r     <= 1'b0;
        ptr_r      <= base_s;
        hold_cnt_r <= '0;
      end
    end else begin
      preempted_r <= 1'b0;
      hold_cnt_r  <= hold_cnt_r + HC_W'(1);
    end
  end

  assign grants    = grants_r;
  assign grant_id  = grant_id_r;
  assign busy      = busy_r;
  assign preempted = preempted_r;

endmodule

// File: tb/tb_round_robin_arbiter_with_lock.sv
// Self-checking bench for round_robin_arbiter_with_lock (N=4, MAX_HOLD=4):
// directed vector table for the listed scenarios, then random traffic against a reference model.
module tb_round_robin_arbiter_with_lock;

  localparam int N    = 4;
  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] requests = 4'b0000;
  logic [3:0] lasts = 4'b0000;
  logic [3:0] grants;
  logic [1:0] grant_id;
  logic       busy;
  logic       preempted;

  round_robin_arbiter_with_lock #(.N(N), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst(rst), .requests(requests), .lasts(lasts),
    .grants(grants), .grant_id(grant_id), .busy(busy), .preempted(preempted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic [3:0] g;
    logic [1:0] id;
    logic       b;
    logic       p;
  } vec_t;

  typedef struct {
    logic [3:0] g;
    logic [1:0] id;
    logic       b;
    logic       p;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  logic [1:0] m_id;
  logic       m_busy;
  logic [1:0] m_ptr;
  int         m_hold;
  logic       m_pre;

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] la,
                     input logic [3:0] g, input logic [1:0] id, input logic b, input logic p);
    vec_t v;
    v.rst = r; v.req = rq; v.last = la; v.g = g; v.id = id; v.b = b; v.p = p;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int step, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b, expected %b", name, step, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
  task automatic apply(input int step, input logic r, input logic [3:0] rq, input logic [3:0] la, input exp_t e);
    exp_t got;
    rst = r; requests = rq; lasts = la;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard step %0d: queue empty, expected one entry", step);
    end else begin
      got = sb.pop_front();
      check("grants",    step, grants, got.g);
      check("grant_id",  step, {2'b00, grant_id}, {2'b00, got.id});
      check("busy",      step, {3'b000, busy}, {3'b000, got.b});
      check("preempted", step, {3'b000, preempted}, {3'b000, got.p});
    end
  endtask

  task automatic model_step(input logic r, input logic [3:0] rq, input logic [3:0] la, output exp_t e);
    logic       d, l, t, rel, found;
    logic [1:0] h, base, w;
    if (r) begin
      m_busy = 1'b0; m_id = 2'd0; m_ptr = 2'd3; m_hold = 0; m_pre = 1'b0;
    end else begin
      h = m_id; d = 1'b0; l = 1'b0; t = 1'b0; rel = 1'b0;
      if (m_busy) begin
        d = ~rq[h];
        l = rq[h] & la[h];
        t = (m_hold == MAXH);
        rel = d | l | t;
      end
      if (!m_busy || rel) begin
        m_pre = m_busy & t & ~d & ~l;
        base = m_busy ? h : m_ptr;
        found = 1'b0; w = 2'd0;
        for (int k = 1; k <= 4; k++) begin
          if (!found && rq[(int'(base) + k) % 4]) begin
            found = 1'b1;
            w = 2'((int'(base) + k) % 4);
          end
        end
        if (found) begin
          m_busy = 1'b1; m_id = w; m_ptr = w; m_hold = 1;
        end else begin
          m_busy = 1'b0; m_ptr = base; m_hold = 0;
        end
      end else begin
        m_hold++;
        m_pre = 1'b0;
      end
    end
    e.g  = m_busy ? (4'b0001 << m_id) : 4'b0000;
    e.id = m_id;
    e.b  = m_busy;
    e.p  = m_pre;
  endtask

  initial begin
    exp_t       e;
    logic       r;
    logic [3:0] rq, la;

    // reset with all requesting, then first grant
    add(1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
    // rotation on last beats
    add(1'b0, 4'b1111, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0);
    add(1'b0, 4'b1111, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(1'b0, 4'b1111, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0);
    add(1'b0, 4'b1111, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(1'b1, 4'b1111, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
    // timeouts alternate between requesters 0 and 2
    for (int i = 0; i < 4; i++) add(1'b0, 4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(1'b0, 4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) add(1'b0, 4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(1'b0, 4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b1);
    // request drop on the holder's second cycle
    add(1'b0, 4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
    // lone requester with last on every beat
    for (int i = 0; i < 11; i++) add(1'b0, 4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    // reset mid-lock, then pointer restarts at 3
    add(1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(1'b1, 4'b0100, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(1'b0, 4'b0110, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0);
    add(1'b0, 4'b0110, 4'b0010, 4'b0100, 2'd2, 1'b1, 1'b0);
    // lone requester timing out is re-granted with a preempted pulse
    for (int i = 0; i < 3; i++) add(1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b1);
    // idle: grant_id holds its last value
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      e.g = vecs[i].g; e.id = vecs[i].id; e.b = vecs[i].b; e.p = vecs[i].p;
      apply(i, vecs[i].rst, vecs[i].req, vecs[i].last, e);
    end

    // random traffic against the reference model, starting from reset
    for (int i = 0; i < 400; i++) begin
      r  = (i == 0) || ($urandom_range(0, 63) == 0);
      rq = 4'($urandom_range(0, 15));
      la = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      if ($urandom_range(0, 3) != 0) rq = rq | (4'b0001 << grant_id);
      model_step(r, rq, la, e);
      apply(1000 + i, r, rq, la, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
